// File: rtl/bridge_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bridge_uart_tx_pkg
// Description : Shared definitions for the host-bridge response path:
//               frame byte constants, nibble-to-ASCII helper and the
//               sequencer / transmitter state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package bridge_uart_tx_pkg;

  localparam logic [7:0] M_CHAR = 8'h4D;
  localparam logic [7:0] CR     = 8'h0D;
  localparam logic [7:0] LF     = 8'h0A;

  // Index of the final byte (LF) in the seven-byte frame.
  localparam logic [2:0] LAST_IDX = 3'd6;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_SEND = 2'd1,
    SEQ_WAIT = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Uppercase hex digit for one nibble: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'.
  // 8'h37 + n equals 8'h41 + (n - 10) for n >= 10.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'b0000, nib};
    end
    return 8'h37 + {4'b0000, nib};
  endfunction

endpackage : bridge_uart_tx_pkg
`default_nettype wire

// File: rtl/bridge_uart_tx_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 UART transmitter. A start request while idle latches
//               one byte and sends start bit, eight data bits LSB first,
//               and a stop bit, each CLOCKS_PER_BAUD cycles long.
// Ports       : clk, rst_n (sync, active-low)
//               data_i[7:0] byte to send, start_i request (honoured when idle)
//               done_o      high while idle, tx serial line (idles high)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
  import bridge_uart_tx_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_i,
  input  logic       start_i,
  output logic       done_o,
  output logic       tx
);

  localparam int BAUD_W = (CLOCKS_PER_BAUD > 2) ? $clog2(CLOCKS_PER_BAUD) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BAUD - 1);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              baud_done;

  assign baud_done = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    case (state_q)
      TX_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (start_i) begin
          shreg_d = data_i;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = TX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = TX_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // The line is registered from the current state, so it trails the state
  // by one cycle; every bit still lasts exactly CLOCKS_PER_BAUD cycles.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shreg_q[bit_q];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  assign done_o = (state_q == TX_IDLE);
  assign tx     = tx_q;

endmodule : uart_tx
`default_nettype wire

// File: rtl/bridge_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : bridge_uart_tx
// Description : Host-bridge response path. A read response word is sent as
//               the ASCII frame 'M' + four uppercase hex digits + CR + LF
//               over an 8N1 UART. Write acks produce no output.
// Ports       : clk, rst_n (sync, active-low)
//               data_i[15:0] response word, rw_i 1=read, valid_i strobe
//               busy_o frame in progress, tx serial line (idles high)
// Revision    : 1.0 - initial release
// ============================================================================
module bridge_uart_tx
  import bridge_uart_tx_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_i,
  input  logic        rw_i,
  input  logic        valid_i,
  output logic        busy_o,
  output logic        tx
);

  seq_state_e  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] word_q, word_d;
  logic        byte_start;
  logic [7:0]  byte_sel;
  logic        tx_done;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    word_d     = word_q;
    byte_start = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (valid_i && rw_i) begin
          word_d  = data_i;
          idx_d   = '0;
          state_d = SEQ_SEND;
        end
      end
      SEQ_SEND: begin
        byte_start = 1'b1;
        state_d    = SEQ_WAIT;
      end
      SEQ_WAIT: begin
        // The transmitter left IDLE on the SEND edge, so done here means
        // the current byte's stop bit has finished.
        if (tx_done) begin
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + 3'd1;
            state_d = SEQ_SEND;
          end else begin
            state_d = SEQ_IDLE;
          end
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_comb begin
    byte_sel = LF;
    case (idx_q)
      3'd0:    byte_sel = M_CHAR;
      3'd1:    byte_sel = hex_ascii(word_q[15:12]);
      3'd2:    byte_sel = hex_ascii(word_q[11:8]);
      3'd3:    byte_sel = hex_ascii(word_q[7:4]);
      3'd4:    byte_sel = hex_ascii(word_q[3:0]);
      3'd5:    byte_sel = CR;
      default: byte_sel = LF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SEQ_IDLE;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

  assign busy_o = (state_q != SEQ_IDLE);

  uart_tx #(
    .CLOCKS_PER_BAUD (CLOCKS_PER_BAUD)
  ) u_uart_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (byte_sel),
    .start_i (byte_start),
    .done_o  (tx_done),
    .tx      (tx)
  );

endmodule : bridge_uart_tx
`default_nettype wire

// File: tb/tb_bridge_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_bridge_uart_tx
// Description : Scoreboard bench for bridge_uart_tx. A frame-level model
//               queues the expected bytes and their start-bit times on each
//               accepted read; a line monitor decodes tx and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bridge_uart_tx;

  localparam int CPB      = 8;
  localparam int FRAME_CY = 70 * CPB + 14;
  localparam int BYTE_CY  = 10 * CPB + 2;

  typedef struct {
    logic [7:0] b;
    int         t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_i = 16'h0;
  logic        rw_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        busy_o;
  logic        tx;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   e      = 0;    // number of rising edges seen so far
  int   rem    = 0;    // model: cycles of busy remaining
  exp_t exp_q[$];

  bridge_uart_tx #(.CLOCKS_PER_BAUD(CPB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .rw_i    (rw_i),
    .valid_i (valid_i),
    .busy_o  (busy_o),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  function automatic logic [7:0] hx(input logic [3:0] n);
    if (n < 10) return 8'd48 + 8'(n);
    return 8'd65 + 8'(n) - 8'd10;
  endfunction

  // Reference model: frame-level behaviour on each rising edge.
  always @(posedge clk) begin
    int   now;
    bit   acc;
    logic [7:0] fr [7];
    now = e;
    e   = e + 1;
    if (!rst_n) begin
      rem = 0;
      exp_q.delete();
    end else begin
      acc = valid_i && rw_i && (rem == 0);
      if (rem > 0) rem--;
      if (acc) begin
        rem   = FRAME_CY;
        fr[0] = 8'h4D;
        fr[1] = hx(data_i[15:12]);
        fr[2] = hx(data_i[11:8]);
        fr[3] = hx(data_i[7:4]);
        fr[4] = hx(data_i[3:0]);
        fr[5] = 8'h0D;
        fr[6] = 8'h0A;
        for (int k = 0; k < 7; k++) exp_q.push_back('{b: fr[k], t: now + 2 + k * BYTE_CY});
      end
    end
  end

  // busy_o against the model every cycle.
  always @(negedge clk) begin
    chk("busy", int'(busy_o), int'(rem > 0));
  end

  // Line monitor: decode each UART byte, check timing, bit stability, value.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        int   fall;
        bit   abort;
        bit   stable;
        logic first;
        logic [7:0] val;
        logic stopb;
        exp_t x;
        fall   = e - 1;
        abort  = 0;
        stable = 1;
        val    = '0;
        stopb  = 1'b0;
        first  = 1'b0;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < CPB; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (!rst_n) begin
              abort = 1;
              break;
            end
            if (c == 0) first = tx;
            else if (tx !== first) stable = 0;
          end
          if (abort) break;
          if (b >= 1 && b <= 8) val[b-1] = first;
          if (b == 9) stopb = first;
        end
        if (!abort) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", int'(val), -1);
          end else begin
            x = exp_q.pop_front();
            chk("byte_value", int'(val), int'(x.b));
            chk("start_time", fall, x.t);
            chk("bit_stable", int'(stable), 1);
            chk("stop_bit", int'(stopb), 1);
          end
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic rw);
    data_i  = d;
    rw_i    = rw;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    data_i  = 16'($urandom);
    rw_i    = 1'($urandom);
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy_o && cnt < 5000) begin
      cnt++;
      @(negedge clk);
    end
    if (cnt >= 5000) chk("idle_timeout", cnt, 0);
  endtask

  initial begin
    int cnt;
    int hi;
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_tx", int'(tx), 1);
    chk("reset_busy", int'(busy_o), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 0x0123 and its busy length
    send(16'h0123, 1'b1);
    wait_idle(cnt);
    chk("busy_len", cnt, FRAME_CY);

    // Hex coverage, back to back (strobe at the first cycle busy is low)
    send(16'h4567, 1'b1);
    wait_idle(cnt);
    send(16'h89AB, 1'b1);
    wait_idle(cnt);
    send(16'hCDEF, 1'b1);
    wait_idle(cnt);
    repeat (4) @(negedge clk);

    // Write ack ignored
    send(16'hFFFF, 1'b0);
    hi = 0;
    for (int i = 0; i < 1000; i++) begin
      if (tx === 1'b1 && busy_o === 1'b0) hi++;
      @(negedge clk);
    end
    chk("write_ignored", hi, 1000);

    // Strobe while busy is dropped
    send(16'h0123, 1'b1);
    repeat (300) @(negedge clk);
    send(16'hBEEF, 1'b1);
    wait_idle(cnt);
    repeat (4) @(negedge clk);

    // Reset in the middle of byte 3
    send(16'h4567, 1'b1);
    repeat (2 + 3 * BYTE_CY + 30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_tx", int'(tx), 1);
    chk("midrst_busy", int'(busy_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send(16'h00FF, 1'b1);
    wait_idle(cnt);
    repeat (3) @(negedge clk);

    // Randomised strobes, some overlapping frames, some writes
    for (int i = 0; i < 10; i++) begin
      send(16'($urandom), 1'($urandom_range(0, 3) != 0));
      repeat ($urandom_range(0, 700)) @(negedge clk);
    end
    wait_idle(cnt);
    repeat (CPB * 12) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_bridge_uart_tx
`default_nettype wire

// File: doc/bridge_uart_tx.md
# bridge_uart_tx

Response path of the host bridge. It accepts a 16-bit read-response word and serialises it as the ASCII frame `M` + four uppercase hex digits + CR + LF. The frame goes out over an 8N1 UART line. The block sits between the bus/core response output and the FPGA's UART TX pin, and combines a byte sequencer with a UART transmitter.

## Interface
- `CLOCKS_PER_BAUD`, default 868, sets the clock cycles per UART bit. The default suits 100 MHz / 115200. Legal values are 2 or greater.
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `data_i`  in  16  response word; sampled only on the accepting edge.
- `rw_i`  in  1  1 = read response (transmit); 0 = write ack (no output).
- `valid_i`  in  1  single-cycle strobe that offers `data_i`/`rw_i`.
- `busy_o`  out  1  high from the accepting edge until the final stop bit completes.
- `tx`  out  1  UART serial output; idles high.

## Operation
- **Accept rule:** the block accepts a transfer when `valid_i`=1, `rw_i`=1 and `busy_o`=0 at a rising edge.
- **Ignored strobes:** `valid_i` is ignored when `rw_i`=0. It is also ignored while `busy_o`=1; there is no queueing.
- **Frame:** on accept, `data_i` is latched and seven bytes are sent in order:
  - 0x4D (`M`)
  - hex(`data_i[15:12]`), hex(`[11:8]`), hex(`[7:4]`), hex(`[3:0]`)
  - 0x0D, 0x0A
- **Hex encoding:** nibble 0–9 maps to 0x30+n; nibble 10–15 maps to 0x41+(n−10), i.e. uppercase.
- **UART format:** 8N1. Each byte is one start bit (0), then eight data bits LSB first, then one stop bit (1). There is no parity.
- **Sequencer states:**
  - IDLE → on accept, go to SEND with index=0.
  - SEND: issue a byte-start pulse, then go to WAIT.
  - WAIT: when the transmitter reports done, go to SEND if index<6 (with index+1), else to IDLE.
- **Transmitter states:** IDLE → START → DATA (bit counter 0..7) → STOP → IDLE. A baud counter runs 0..`CLOCKS_PER_BAUD`−1 in each bit state.
- **Reset:** in reset, `tx`=1, `busy_o`=0, both FSMs are IDLE, and all counters are 0.
- **Reset mid-frame:** asserting reset mid-frame aborts at that edge. `tx` returns high on that edge and no remaining bytes are sent.

## Timing
- **Start latency:** the accepting edge is E. `tx` falls (start bit of `M`) at edge E+2, i.e. 1 cycle for the sequencer plus 1 for the transmitter latch.
- **Bit duration:** every bit, including the start and stop bits, holds exactly `CLOCKS_PER_BAUD` cycles.
- **Inter-byte gap:** after a stop bit completes, the next start bit begins exactly 2 cycles later, with `tx` held high during the gap.
- **Frame duration:** 70·`CLOCKS_PER_BAUD` + 14 cycles from E to `busy_o` falling. `busy_o` falls on the same edge at which the last stop bit ends.
- **Back-to-back frames:** a new `valid_i` is accepted at the edge where `busy_o` is first sampled 0. This allows frames back to back.
- **Data hold:** `data_i` may change freely after the accepting edge.

## Structure
- **Shared package:**
  - byte constants `M_CHAR`=8'h4D, `CR`=8'h0D, `LF`=8'h0A
  - a hex-nibble-to-ASCII function
  - the sequencer state enum
- **Sub-module `uart_tx`:**
  - parameter: `CLOCKS_PER_BAUD`
  - inputs: `clk`, `rst_n`, `data_i[7:0]`, `start_i`
  - outputs: `done_o`, `tx`
  - `done_o` is a level, high while the transmitter is IDLE.
  - `start_i` is honoured only when `done_o`=1, and latches `data_i`.
- **Top level:** the byte sequencer instantiates `uart_tx`. The sequencer uses a 3-bit index and an ASCII mux.

## Test plan
- **Frame 0x0123 (`CLOCKS_PER_BAUD`=8):** reset, then `data_i`=0x0123, `rw_i`=1, one-cycle `valid_i`.
  - Decoded bytes must be 4D 30 31 32 33 0D 0A.
  - `busy_o` must be high for 574 cycles.
- **Hex digit coverage:** send 0x4567, 0x89AB and 0xCDEF in sequence.
  - Required bytes: 4D 34 35 36 37 0D 0A, then 4D 38 39 41 42 0D 0A, then 4D 43 44 45 46 0D 0A.
- **Bit timing:** each bit lasts exactly 8 cycles; the start bit falls 2 cycles after accept; the gap between bytes is 2 cycles; data goes LSB first; the stop bit is high.
- **Write ignored:** `valid_i` with `rw_i`=0 and `data_i`=0xFFFF → `tx` stays 1 and `busy_o` stays 0 for 1000 cycles.
- **Busy drop:** start 0x0123, then pulse `valid_i` with 0xBEEF mid-frame → the only frame sent is `M0123\r\n`; 0xBEEF is dropped.
- **Reset mid-frame:** pull `rst_n` low during byte 3 → `tx`=1 and `busy_o`=0 from that edge. After release, a new 0x00FF request must yield 4D 30 30 46 46 0D 0A.
